// File: rtl/fetch_pkg.sv
// Types and constants shared by the fetch-stage predictors: BHT, local PHT and chooser.
package fetch_pkg;

    localparam int LHIST_W = 10;
    localparam int LCNT_W  = 3;

    localparam logic [LCNT_W-1:0] LPHT_INIT_VAL = 3'b011;

    typedef enum logic {
        LPHT_INIT = 1'b0,
        LPHT_RUN  = 1'b1
    } lpht_state_e;

endpackage

// File: rtl/sat_ctr_next.sv
// Next value of an unsigned saturating counter: up_i steps toward all-ones, otherwise toward zero.
module sat_ctr_next #(
    parameter int CNT_W = 3
) (
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             up_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Saturating step; the extreme values are sticky in their own direction.
    always_comb begin
        cnt_o = cnt_i;
        if (up_i) begin
            if (cnt_i != CNT_MAX) cnt_o = cnt_i + CNT_ONE;
            else                  cnt_o = CNT_MAX;
        end else begin
            if (cnt_i != CNT_ZERO) cnt_o = cnt_i - CNT_ONE;
            else                   cnt_o = CNT_ZERO;
        end
    end

endmodule

// File: rtl/lpht.sv
// Local pattern history table: 2**IDX_W saturating counters indexed by BHT local history,
// registered lookup, write-first update bypass and a post-reset init sweep.
module lpht
    import fetch_pkg::*;
#(
    parameter int               IDX_W    = LHIST_W,
    parameter int               CNT_W    = LCNT_W,
    parameter logic [CNT_W-1:0] INIT_VAL = LPHT_INIT_VAL
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             lpht_rd_valid_i,
    input  logic [IDX_W-1:0] lpht_rd_hist_i,
    output logic             lpht_pred_valid_o,
    output logic             lpht_pred_taken_o,
    output logic [CNT_W-1:0] lpht_pred_cnt_o,
    input  logic             lpht_upd_en_i,
    input  logic [IDX_W-1:0] lpht_upd_hist_i,
    input  logic             lpht_upd_taken_i,
    output logic             lpht_ready_o
);

    localparam int BANK_W = IDX_W / 2;
    localparam int ROW_W  = IDX_W - BANK_W;
    localparam int NBANK  = 2 ** BANK_W;
    localparam int NROW   = 2 ** ROW_W;

    localparam logic [IDX_W-1:0] IDX_MAX = '1;
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    lpht_state_e      state_q, state_d;
    logic [IDX_W-1:0] init_idx_q, init_idx_d;
    logic             ready_q, ready_d;
    logic             pred_valid_q, pred_valid_d;
    logic             pred_taken_q, pred_taken_d;
    logic [CNT_W-1:0] pred_cnt_q, pred_cnt_d;

    logic                        run_s;
    logic                        upd_fire_s;
    logic                        wr_en_s;
    logic [IDX_W-1:0]            wr_idx_s;
    logic [CNT_W-1:0]            wr_data_s;
    logic [NBANK-1:0]            bank_we_s;
    logic [NBANK-1:0][CNT_W-1:0] rd_bank_s;
    logic [NBANK-1:0][CNT_W-1:0] upd_bank_s;
    logic [CNT_W-1:0]            upd_cur_s;
    logic [CNT_W-1:0]            upd_next_s;
    logic [CNT_W-1:0]            rd_cnt_s;

    assign run_s      = (state_q == LPHT_RUN);
    assign upd_fire_s = run_s & lpht_upd_en_i;

    // The single write port is owned by the init sweep until RUN, then by committed updates.
    assign wr_en_s   = ~run_s | upd_fire_s;
    assign wr_idx_s  = run_s ? lpht_upd_hist_i : init_idx_q;
    assign wr_data_s = run_s ? upd_next_s : INIT_VAL;

    // One-hot bank write enable so only the addressed bank clocks new data.
    always_comb begin
        bank_we_s = '0;
        if (wr_en_s) bank_we_s[wr_idx_s[IDX_W-1:ROW_W]] = 1'b1;
        else         bank_we_s = '0;
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic [CNT_W-1:0] bank_q [NROW];

        // Bank storage; contents are defined by the init sweep rather than by reset.
        always_ff @(posedge clock) begin
            if (bank_we_s[b]) bank_q[wr_idx_s[ROW_W-1:0]] <= wr_data_s;
        end

        assign rd_bank_s[b]  = bank_q[lpht_rd_hist_i[ROW_W-1:0]];
        assign upd_bank_s[b] = bank_q[lpht_upd_hist_i[ROW_W-1:0]];
    end

    assign upd_cur_s = upd_bank_s[lpht_upd_hist_i[IDX_W-1:ROW_W]];

    sat_ctr_next #(
        .CNT_W (CNT_W)
    ) u_sat_ctr_next (
        .cnt_i (upd_cur_s),
        .up_i  (lpht_upd_taken_i),
        .cnt_o (upd_next_s)
    );

    // Write-first: a lookup colliding with this cycle's update sees the trained value.
    assign rd_cnt_s = (upd_fire_s && (lpht_upd_hist_i == lpht_rd_hist_i))
                    ? upd_next_s
                    : rd_bank_s[lpht_rd_hist_i[IDX_W-1:ROW_W]];

    // Init sweep sequencing and lookup result capture.
    always_comb begin
        state_d      = state_q;
        init_idx_d   = init_idx_q;
        pred_cnt_d   = pred_cnt_q;
        pred_taken_d = pred_taken_q;
        case (state_q)
            LPHT_INIT: begin
                init_idx_d = init_idx_q + IDX_ONE;
                if (init_idx_q == IDX_MAX) state_d = LPHT_RUN;
                else                       state_d = LPHT_INIT;
            end
            LPHT_RUN: begin
                state_d = LPHT_RUN;
            end
            default: begin
                state_d    = LPHT_INIT;
                init_idx_d = '0;
            end
        endcase
        ready_d      = (state_d == LPHT_RUN);
        pred_valid_d = lpht_rd_valid_i & ready_q;
        if (pred_valid_d) begin
            pred_cnt_d   = rd_cnt_s;
            pred_taken_d = rd_cnt_s[CNT_W-1];
        end else begin
            pred_cnt_d   = pred_cnt_q;
            pred_taken_d = pred_taken_q;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= LPHT_INIT;
            init_idx_q   <= '0;
            ready_q      <= 1'b0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            init_idx_q   <= init_idx_d;
            ready_q      <= ready_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_cnt_q   <= pred_cnt_d;
        end
    end

    assign lpht_pred_valid_o = pred_valid_q;
    assign lpht_pred_taken_o = pred_taken_q;
    assign lpht_pred_cnt_o   = pred_cnt_q;
    assign lpht_ready_o      = ready_q;

endmodule

// File: tb/tb_lpht.sv
// Directed bench for lpht: init sweep timing, saturation, bypass, dropped INIT traffic, reset replay.
module tb_lpht;

    logic       clock;
    logic       reset;
    logic       rd_valid_s;
    logic [9:0] rd_hist_s;
    logic       pred_valid_s;
    logic       pred_taken_s;
    logic [2:0] pred_cnt_s;
    logic       upd_en_s;
    logic [9:0] upd_hist_s;
    logic       upd_taken_s;
    logic       ready_s;

    int n_vec;
    int n_err;

    lpht dut (
        .clock             (clock),
        .reset             (reset),
        .lpht_rd_valid_i   (rd_valid_s),
        .lpht_rd_hist_i    (rd_hist_s),
        .lpht_pred_valid_o (pred_valid_s),
        .lpht_pred_taken_o (pred_taken_s),
        .lpht_pred_cnt_o   (pred_cnt_s),
        .lpht_upd_en_i     (upd_en_s),
        .lpht_upd_hist_i   (upd_hist_s),
        .lpht_upd_taken_i  (upd_taken_s),
        .lpht_ready_o      (ready_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic lookup(input logic [9:0] h, input logic [2:0] exp_cnt, input string tag);
        rd_valid_s = 1'b1;
        rd_hist_s  = h;
        tick();
        rd_valid_s = 1'b0;
        check({tag, "_valid"}, 32'(pred_valid_s), 32'd1);
        check({tag, "_cnt"},   32'(pred_cnt_s),   32'(exp_cnt));
        check({tag, "_taken"}, 32'(pred_taken_s), 32'(exp_cnt[2]));
    endtask

    task automatic update(input logic [9:0] h, input logic tk);
        upd_en_s    = 1'b1;
        upd_hist_s  = h;
        upd_taken_s = tk;
        tick();
        upd_en_s = 1'b0;
    endtask

    // Runs INIT with junk lookups/updates at 0x010 until ready; returns cycles counted.
    task automatic run_init(output int cyc, output logic saw_valid);
        cyc        = 0;
        saw_valid  = 1'b0;
        rd_valid_s = 1'b1;
        rd_hist_s  = 10'h010;
        upd_en_s   = 1'b1;
        upd_hist_s = 10'h010;
        upd_taken_s = 1'b1;
        reset = 1'b0;
        while (!ready_s && cyc < 2000) begin
            tick();
            cyc++;
            if (pred_valid_s) saw_valid = 1'b1;
        end
        rd_valid_s = 1'b0;
        upd_en_s   = 1'b0;
    endtask

    initial begin
        int   cyc;
        logic saw_valid;
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        rd_valid_s = 1'b0;
        rd_hist_s  = 10'h000;
        upd_en_s   = 1'b0;
        upd_hist_s = 10'h000;
        upd_taken_s = 1'b0;
        repeat (3) tick();
        check("rst_ready", 32'(ready_s),      32'd0);
        check("rst_valid", 32'(pred_valid_s), 32'd0);
        check("rst_cnt",   32'(pred_cnt_s),   32'd0);
        check("rst_taken", 32'(pred_taken_s), 32'd0);

        run_init(cyc, saw_valid);
        check("init_cycles",   32'(cyc),       32'd1024);
        check("init_no_valid", 32'(saw_valid), 32'd0);
        check("init_valid_at_ready", 32'(pred_valid_s), 32'd0);

        lookup(10'h3FF, 3'd3, "last_entry");
        lookup(10'h010, 3'd3, "init_upd_dropped");
        lookup(10'h000, 3'd3, "first_entry");

        for (int i = 0; i < 5; i++) update(10'h155, 1'b1);
        lookup(10'h155, 3'd7, "sat_high");
        for (int i = 0; i < 8; i++) update(10'h155, 1'b0);
        lookup(10'h155, 3'd0, "sat_low");
        update(10'h155, 1'b0);
        lookup(10'h155, 3'd0, "no_wrap");
        update(10'h155, 1'b1);
        lookup(10'h155, 3'd1, "inc_from_zero");

        for (int i = 0; i < 3; i++) update(10'h0C3, 1'b1);
        lookup(10'h0C3, 3'd6, "accumulate");

        // Same-cycle lookup and update to 0x0AA.
        upd_en_s = 1'b1; upd_hist_s = 10'h0AA; upd_taken_s = 1'b1;
        lookup(10'h0AA, 3'd4, "bypass");
        upd_en_s = 1'b0;

        // Independent indices in the same cycle.
        upd_en_s = 1'b1; upd_hist_s = 10'h002; upd_taken_s = 1'b1;
        lookup(10'h001, 3'd3, "indep_rd");
        upd_en_s = 1'b0;
        lookup(10'h002, 3'd4, "indep_wr");

        tick();
        check("idle_valid",     32'(pred_valid_s), 32'd0);
        check("idle_cnt_hold",  32'(pred_cnt_s),   32'd4);
        check("idle_taken_hold", 32'(pred_taken_s), 32'd1);

        for (int i = 0; i < 3; i++) update(10'h020, 1'b1);
        lookup(10'h020, 3'd6, "pre_reset");

        // Reset pulse with a lookup pending in the same cycle.
        rd_valid_s = 1'b1; rd_hist_s = 10'h020;
        reset = 1'b1;
        tick();
        rd_valid_s = 1'b0;
        check("rerst_valid", 32'(pred_valid_s), 32'd0);
        check("rerst_ready", 32'(ready_s),      32'd0);

        run_init(cyc, saw_valid);
        check("reinit_cycles",   32'(cyc),       32'd1024);
        check("reinit_no_valid", 32'(saw_valid), 32'd0);
        lookup(10'h020, 3'd3, "post_reinit");
        lookup(10'h155, 3'd3, "post_reinit_155");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lpht.md
Name: lpht

Overview:
- Local Pattern History Table: 1024 x 3-bit saturating counters, indexed by the 10-bit local history that the BHT produces (bht_br_hist_o).
- Sits directly downstream of the BHT in the fetch stage and supplies the local taken/not-taken prediction to the branch chooser.
- Read path is registered, with 1-cycle latency. Counters are trained from committed branches.
- A post-reset init sequencer walks the table so that no RAM-style bulk reset is needed.

Parameters:
- IDX_W, 10, history/index width; table depth = 2**IDX_W.
- CNT_W, 3, counter width.
- INIT_VAL, 3'b011, counter value written to every entry after reset (weakly not-taken).

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- lpht_rd_valid_i  in  1  lookup request this cycle.
- lpht_rd_hist_i  in  IDX_W  lookup index; this is the local history from the BHT.
- lpht_pred_valid_o  out  1  prediction valid; applies to the request from the previous cycle.
- lpht_pred_taken_o  out  1  predicted direction, equal to counter MSB.
- lpht_pred_cnt_o  out  CNT_W  raw counter value, for the chooser and debug.
- lpht_upd_en_i  in  1  committed-branch update strobe.
- lpht_upd_hist_i  in  IDX_W  history that was used when the committed branch was predicted.
- lpht_upd_taken_i  in  1  resolved direction.
- lpht_ready_o  out  1  table initialised; lookups and updates are honoured.

Behaviour:
- State machine, two states: INIT and RUN.
  - Reset forces INIT with init_idx=0.
  - In INIT, each cycle writes INIT_VAL to entry init_idx, then increments init_idx.
  - On the cycle that writes entry 1023, the next state is RUN. INIT therefore lasts exactly 1024 cycles.
  - RUN is terminal until the next reset.
- Reset values: lpht_pred_valid_o=0, lpht_pred_taken_o=0, lpht_pred_cnt_o=0, lpht_ready_o=0, init_idx=0.
- lpht_ready_o is registered. It is 1 from the first cycle after the final INIT write.
- A reset asserted mid-INIT or in RUN restarts INIT at index 0. Any pending prediction is dropped (pred_valid_o=0 next cycle).
- Lookup:
  - lpht_pred_valid_o(t+1) = lpht_rd_valid_i(t) & ready(t).
  - Counter output (t+1) = table[lpht_rd_hist_i(t)] after applying any update in cycle t.
  - lpht_pred_taken_o = counter[CNT_W-1].
  - When valid is 0, pred_taken/pred_cnt hold their previous values.
- Lookups while not ready produce no valid output and are not queued.
- Update (RUN only):
  - In cycle t, the entry at lpht_upd_hist_i is written with the saturated next value. It is visible to a lookup starting at t+1.
  - Taken: cnt = (cnt==7) ? 7 : cnt+1.
  - Not taken: cnt = (cnt==0) ? 0 : cnt-1.
  - No wrap-around, in either direction.
- Updates during INIT are silently dropped.
- Same-cycle read/update to the same index: the lookup returns the updated value (write-first bypass).
- Read and update to different indices in the same cycle are fully independent.
- At most one update per cycle. Back-to-back updates to the same index accumulate, e.g. 3 taken updates from 3 yield 6.
- Counter logic is purely unsigned, CNT_W bits. Index arithmetic is modulo 2**IDX_W.

Decomposition:
- Shared package fetch_pkg holds:
  - LHIST_W=10 and LCNT_W=3;
  - LPHT_INIT_VAL=3'b011;
  - the enum lpht_state_e {LPHT_INIT, LPHT_RUN}.
  The BHT, lpht and chooser all import it.
- One sub-module, sat_ctr_next: combinational saturating increment/decrement of a CNT_W value given a direction. It is reused by the chooser and global PHT.
- Storage is plain registers, banked 32x32 with a per-bank write enable for power. This mirrors the BHT organisation.

Test Plan:
- Reset held 3 cycles, then released → ready_o=0 for 1024 cycles, ready_o=1 on the next cycle; a lookup at index 0x3FF returns cnt=3, taken=0.
- After ready, 5 taken updates to 0x155, then lookup 0x155 → cnt=7, taken=1 (saturated at 4th update, stays 7); 8 not-taken updates → cnt=0, never wraps to 7.
- Lookup 0x0AA and update 0x0AA taken in the same cycle (entry=3) → next cycle pred_cnt_o=4, pred_taken_o=1 (bypass).
- Lookup 0x001 with update 0x002 in the same cycle → lookup returns 3; entry 0x002 becomes 4 on the following lookup.
- During INIT, issue rd_valid_i=1 and an update at 0x010 → pred_valid_o stays 0; after ready, 0x010 reads 3 (update dropped).
- In RUN, entry 0x020 trained to 6, then reset pulsed 1 cycle mid-stream → pred_valid_o=0 next cycle, ready_o=0, full 1024-cycle INIT replays, 0x020 reads 3.
